// File: rtl/ecap5_dproc_pkg.sv
// ecap5_dproc_pkg: shared arbitration mode and FSM state types for the Wishbone arbiter
package ecap5_dproc_pkg;
    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_t;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;
endpackage

// File: rtl/wb_arb_select.sv
// wb_arb_select: combinational one-hot winner pick, fixed priority or round-robin from ptr
module wb_arb_select
    import ecap5_dproc_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  arb_mode_t     mode,
    output logic [N-1:0]  winner
);
    always_comb begin
        int s;
        int idx;
        winner = '0;
        s = 0;
        idx = 0;
        // Walk from the lowest priority down so the highest-priority hit is written last.
        for (int i = N - 1; i >= 0; i--) begin
            s = int'(ptr) + i;
            idx = (mode == ARB_RR) ? ((s >= N) ? s - N : s) : i;
            if (req[idx]) winner = N'(1) << idx;
        end
    end
endmodule

// File: rtl/wb_arbiter_n.sv
// wb_arbiter_n: N-master to 1-slave pipelined Wishbone arbiter with locking and outstanding limit
module wb_arbiter_n
    import ecap5_dproc_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int ARB_MODE        = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_MASTERS-1:0][31:0] s_wb_adr_i,
    input  logic [NUM_MASTERS-1:0][31:0] s_wb_dat_i,
    output logic [31:0]                  s_wb_dat_o,
    input  logic [NUM_MASTERS-1:0][3:0]  s_wb_sel_i,
    input  logic [NUM_MASTERS-1:0]       s_wb_we_i,
    input  logic [NUM_MASTERS-1:0]       s_wb_stb_i,
    input  logic [NUM_MASTERS-1:0]       s_wb_cyc_i,
    output logic [NUM_MASTERS-1:0]       s_wb_ack_o,
    output logic [NUM_MASTERS-1:0]       s_wb_stall_o,
    output logic [31:0]                  m_wb_adr_o,
    output logic [31:0]                  m_wb_dat_o,
    output logic [3:0]                   m_wb_sel_o,
    output logic                         m_wb_we_o,
    output logic                         m_wb_stb_o,
    output logic                         m_wb_cyc_o,
    input  logic [31:0]                  m_wb_dat_i,
    input  logic                         m_wb_ack_i,
    input  logic                         m_wb_stall_i,
    output logic [NUM_MASTERS-1:0]       grant_o
);
    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t           state;
    logic [NUM_MASTERS-1:0] winner;
    logic [PW-1:0]        ptr, widx, ptr_next;
    logic [CW-1:0]        count;
    logic                 busy, gcyc, gstb, active, full, accept, ack_ok;

    wb_arb_select #(.N(NUM_MASTERS), .PW(PW)) u_select (
        .req    (s_wb_cyc_i),
        .ptr    (ptr),
        .mode   (arb_mode_t'(ARB_MODE)),
        .winner (winner)
    );

    always_comb begin
        widx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (winner[i]) widx = PW'(i);
        ptr_next = (widx == PW'(NUM_MASTERS - 1)) ? '0 : widx + 1'b1;
    end

    always_comb begin
        m_wb_adr_o = '0;
        m_wb_dat_o = '0;
        m_wb_sel_o = '0;
        m_wb_we_o  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (grant_o[i]) begin
                m_wb_adr_o = s_wb_adr_i[i];
                m_wb_dat_o = s_wb_dat_i[i];
                m_wb_sel_o = s_wb_sel_i[i];
                m_wb_we_o  = s_wb_we_i[i];
            end
    end

    assign busy         = state == ARB_BUSY;
    assign gcyc         = |(s_wb_cyc_i & grant_o);
    assign gstb         = |(s_wb_stb_i & grant_o);
    assign active       = busy & gcyc;
    assign full         = count == CW'(MAX_OUTSTANDING);
    assign m_wb_cyc_o   = active;
    assign m_wb_stb_o   = active & gstb & ~full;
    assign accept       = m_wb_stb_o & ~m_wb_stall_i;
    assign ack_ok       = m_wb_ack_i & busy & (count != '0);
    assign s_wb_ack_o   = grant_o & {NUM_MASTERS{ack_ok}};
    assign s_wb_stall_o = busy ? (~grant_o | {NUM_MASTERS{m_wb_stall_i | full}}) : '1;
    assign s_wb_dat_o   = m_wb_dat_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ARB_IDLE;
            grant_o <= '0;
            ptr     <= '0;
        end else if (!busy) begin
            if (|s_wb_cyc_i) begin
                state   <= ARB_BUSY;
                grant_o <= winner;
                ptr     <= ptr_next;
            end
        end else if (!gcyc) begin
            state   <= ARB_IDLE;
            grant_o <= '0;
        end
    end

    // Any cycle without a live granted cyc discards outstanding state so late acks look spurious.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count <= '0;
        else         count <= active ? count + CW'(accept) - CW'(ack_ok) : '0;
    end
endmodule

// File: tb/tb_wb_arbiter_n.sv
// tb_wb_arbiter_n: directed table and sequence checks for the Wishbone arbiter
module tb_wb_arbiter_n;
    import ecap5_dproc_pkg::*;

    localparam logic [31:0] A0 = 32'h1000_0000, A1 = 32'h1000_0004, A2 = 32'h1000_0008;
    localparam logic [31:0] A3 = 32'h1000_000C, A4 = 32'h1000_0010, B = 32'h2000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][31:0] adr_a, dat_a;
    logic [1:0][3:0]  sel_a;
    logic [1:0]       we_a, stb_a, cyc_a, ack_a, stall_a, grant_a;
    logic [31:0]      sdat_a, madr_a, mdat_a;
    logic [3:0]       msel_a;
    logic             mwe_a, mstb_a, mcyc_a, mack_a, mstall_a;

    wb_arbiter_n #(.NUM_MASTERS(2), .ARB_MODE(0), .MAX_OUTSTANDING(2)) u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .s_wb_adr_i(adr_a), .s_wb_dat_i(dat_a), .s_wb_dat_o(sdat_a), .s_wb_sel_i(sel_a),
        .s_wb_we_i(we_a), .s_wb_stb_i(stb_a), .s_wb_cyc_i(cyc_a),
        .s_wb_ack_o(ack_a), .s_wb_stall_o(stall_a),
        .m_wb_adr_o(madr_a), .m_wb_dat_o(mdat_a), .m_wb_sel_o(msel_a), .m_wb_we_o(mwe_a),
        .m_wb_stb_o(mstb_a), .m_wb_cyc_o(mcyc_a),
        .m_wb_dat_i(32'hDEAD_BEEF), .m_wb_ack_i(mack_a), .m_wb_stall_i(mstall_a),
        .grant_o(grant_a)
    );

    logic [2:0][31:0] adr_b, dat_b;
    logic [2:0][3:0]  sel_b;
    logic [2:0]       we_b, stb_b, cyc_b, ack_b, stall_b, grant_b;
    logic [31:0]      sdat_b, madr_b, mdat_b;
    logic [3:0]       msel_b;
    logic             mwe_b, mstb_b, mcyc_b, mack_b;

    wb_arbiter_n #(.NUM_MASTERS(3), .ARB_MODE(1), .MAX_OUTSTANDING(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .s_wb_adr_i(adr_b), .s_wb_dat_i(dat_b), .s_wb_dat_o(sdat_b), .s_wb_sel_i(sel_b),
        .s_wb_we_i(we_b), .s_wb_stb_i(stb_b), .s_wb_cyc_i(cyc_b),
        .s_wb_ack_o(ack_b), .s_wb_stall_o(stall_b),
        .m_wb_adr_o(madr_b), .m_wb_dat_o(mdat_b), .m_wb_sel_o(msel_b), .m_wb_we_o(mwe_b),
        .m_wb_stb_o(mstb_b), .m_wb_cyc_o(mcyc_b),
        .m_wb_dat_i(32'h0), .m_wb_ack_i(mack_b), .m_wb_stall_i(1'b0),
        .grant_o(grant_b)
    );

    typedef struct {
        logic [1:0]  cyc, stb;
        logic [31:0] adr0;
        logic        mstall, mack;
        logic [1:0]  grant, stall, ack;
        logic        mcyc, mstb;
        logic [31:0] madr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t tv[27];
    logic [2:0] rr_exp[4];

    initial begin
        // cyc stb adr0 mstall mack | grant stall ack mcyc mstb madr
        tv[0]  = '{2'b10, 2'b00, A0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 32'h0};
        tv[1]  = '{2'b10, 2'b00, A0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 1'b1, 1'b0, B};
        tv[2]  = '{2'b11, 2'b00, A0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 1'b1, 1'b0, B};
        tv[3]  = '{2'b11, 2'b10, A0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 1'b1, 1'b1, B};
        tv[4]  = '{2'b11, 2'b00, A0, 1'b0, 1'b1, 2'b10, 2'b01, 2'b10, 1'b1, 1'b0, B};
        tv[5]  = '{2'b01, 2'b00, A0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, B};
        tv[6]  = '{2'b01, 2'b00, A0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 32'h0};
        tv[7]  = '{2'b01, 2'b00, A0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1, 1'b0, A0};
        tv[8]  = '{2'b01, 2'b01, A1, 1'b1, 1'b0, 2'b01, 2'b11, 2'b00, 1'b1, 1'b1, A1};
        tv[9]  = '{2'b01, 2'b01, A1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1, 1'b1, A1};
        tv[10] = '{2'b01, 2'b01, A2, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1, 1'b1, A2};
        tv[11] = '{2'b01, 2'b01, A3, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00, 1'b1, 1'b0, A3};
        tv[12] = '{2'b01, 2'b01, A3, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00, 1'b1, 1'b0, A3};
        tv[13] = '{2'b01, 2'b01, A3, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00, 1'b1, 1'b0, A3};
        tv[14] = '{2'b01, 2'b01, A3, 1'b0, 1'b1, 2'b01, 2'b11, 2'b01, 1'b1, 1'b0, A3};
        tv[15] = '{2'b01, 2'b01, A3, 1'b0, 1'b1, 2'b01, 2'b10, 2'b01, 1'b1, 1'b1, A3};
        tv[16] = '{2'b01, 2'b01, A4, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1, 1'b1, A4};
        tv[17] = '{2'b01, 2'b00, A4, 1'b0, 1'b1, 2'b01, 2'b11, 2'b01, 1'b1, 1'b0, A4};
        tv[18] = '{2'b01, 2'b00, A4, 1'b0, 1'b1, 2'b01, 2'b10, 2'b01, 1'b1, 1'b0, A4};
        tv[19] = '{2'b01, 2'b00, A4, 1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 1'b1, 1'b0, A4};
        tv[20] = '{2'b11, 2'b01, A1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1, 1'b1, A1};
        tv[21] = '{2'b11, 2'b01, A2, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1, 1'b1, A2};
        tv[22] = '{2'b10, 2'b00, A2, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0, 1'b0, A2};
        tv[23] = '{2'b10, 2'b00, A2, 1'b0, 1'b1, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 32'h0};
        tv[24] = '{2'b10, 2'b00, A2, 1'b0, 1'b1, 2'b10, 2'b01, 2'b00, 1'b1, 1'b0, B};
        tv[25] = '{2'b00, 2'b00, A2, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, B};
        tv[26] = '{2'b00, 2'b00, A2, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 32'h0};
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b010;
        rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001;

        adr_a = {B, A0}; dat_a = '0; sel_a = '1; we_a = '0; stb_a = '0; cyc_a = 2'b11;
        mack_a = 1'b0; mstall_a = 1'b0;
        adr_b = '0; dat_b = '0; sel_b = '0; we_b = '0; stb_b = '0; cyc_b = '0; mack_b = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset mcyc", 32'(mcyc_a), 32'h0);
        chk("reset stall", 32'(stall_a), 32'h3);
        chk("reset grant", 32'(grant_a), 32'h0);
        chk("reset ack", 32'(ack_a), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post-reset grant", 32'(grant_a), 32'h1);
        cyc_a = 2'b00;

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            cyc_a = tv[i].cyc;
            stb_a = tv[i].stb;
            adr_a = {B, tv[i].adr0};
            mstall_a = tv[i].mstall;
            mack_a = tv[i].mack;
            #1;
            chk($sformatf("row%0d grant", i), 32'(grant_a), 32'(tv[i].grant));
            chk($sformatf("row%0d stall", i), 32'(stall_a), 32'(tv[i].stall));
            chk($sformatf("row%0d ack", i), 32'(ack_a), 32'(tv[i].ack));
            chk($sformatf("row%0d mcyc", i), 32'(mcyc_a), 32'(tv[i].mcyc));
            chk($sformatf("row%0d mstb", i), 32'(mstb_a), 32'(tv[i].mstb));
            chk($sformatf("row%0d madr", i), madr_a, tv[i].madr);
        end

        // Asynchronous reset in the middle of a granted cycle.
        @(negedge clk);
        cyc_a = 2'b01;
        @(negedge clk);
        stb_a = 2'b01;
        #1;
        chk("pre-reset mcyc", 32'(mcyc_a), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset mcyc", 32'(mcyc_a), 32'h0);
        chk("async reset grant", 32'(grant_a), 32'h0);
        chk("async reset stall", 32'(stall_a), 32'h3);
        @(negedge clk);
        rst_n = 1'b1;
        cyc_a = 2'b00;
        stb_a = 2'b00;

        // Round-robin: each master releases after a single acked strobe.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cyc_b = 3'b111;
            @(negedge clk);
            stb_b = rr_exp[k];
            #1;
            chk($sformatf("rr%0d grant", k), 32'(grant_b), 32'(rr_exp[k]));
            @(negedge clk);
            stb_b = 3'b000;
            mack_b = 1'b1;
            #1;
            chk($sformatf("rr%0d ack", k), 32'(ack_b), 32'(rr_exp[k]));
            @(negedge clk);
            mack_b = 1'b0;
            cyc_b = 3'b111 & ~rr_exp[k];
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
